cmult_pipe: RTL and testbench

Parametrised, pipelined complex multiplier for the FFT butterfly datapath. It multiplies a DW-bit complex sample by a TW-bit complex twiddle factor in Q(FRAC) format. Each rail is rounded half-up and saturated back to DW bits. A valid/ready handshake carries backpressure, and a per-sample conjugate mode lets the same block serve forward and inverse transforms. It sits between the twiddle ROM / sample buffer and the butterfly add/sub stage.

---
 rtl/cmult_pipe.sv | 152 +++++++++++++++
 tb/tb_cmult_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmult_pipe.sv
// cmult_pipe: three-stage pipelined complex multiplier for the FFT butterfly
// datapath. Multiplies a DW-bit complex sample by a TW-bit Q(FRAC) twiddle,
// optionally conjugating the twiddle per sample. Each rail is rounded half-up
// and saturated to DW bits. A single advance enable stalls the whole pipe when
// the output is held by downstream backpressure.
module cmult_pipe #(
   parameter int DW   = 16,
   parameter int TW   = 12,
   parameter int FRAC = 10,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_conj,
   input  logic [DW-1:0]   in_re,
   input  logic [DW-1:0]   in_im,
   input  logic [TW-1:0]   tw_re,
   input  logic [TW-1:0]   tw_im,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_re,
   output logic [DW-1:0]   out_im,
   output logic            out_ovf,
   input  logic            clr_stats,
   output logic [CNTW-1:0] ovf_count
);

   // Full-precision product width and sum width (one extra bit so add/sub
   // never wraps).
   localparam int PW = DW + TW;
   localparam int SW = PW + 1;

   // Rounding constant 2^(FRAC-1) and the DW-bit signed limits, all at sum width.
   localparam logic signed [SW-1:0] RND  = {{(SW-1){1'b0}}, 1'b1} << (FRAC - 1);
   localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic en;
   logic v1, v2, v3;

   // Stage 1 operands
   logic signed [DW-1:0] a1, b1;
   logic signed [TW-1:0] c1, d1;
   logic                 conj1;

   // Stage 2 products
   logic signed [PW-1:0] p_ac, p_bd, p_ad, p_bc;
   logic                 conj2;

   // Stage 3 combinational results
   logic signed [SW-1:0] re_sum, im_sum;
   logic [DW-1:0]        re_q, im_q;
   logic                 re_ovf, im_ovf;

   // The whole pipe advances together unless a result is stuck at the output.
   assign en        = !v3 || out_ready;
   assign in_ready  = en;
   assign out_valid = v3;

   // Round half-up (add half LSB, arithmetic shift) then clamp to DW bits.
   function automatic void rnd_sat(input  logic signed [SW-1:0] v,
                                   output logic [DW-1:0]        q,
                                   output logic                 ovf);
      logic signed [SW-1:0] r;
      r = (v + RND) >>> FRAC;
      if (r > SMAX) begin
         q   = SMAX[DW-1:0];
         ovf = 1'b1;
      end else if (r < SMIN) begin
         q   = SMIN[DW-1:0];
         ovf = 1'b1;
      end else begin
         q   = r[DW-1:0];
         ovf = 1'b0;
      end
   endfunction

   // Valid bits shift in lockstep whenever the pipe advances; bubbles are kept.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (en) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
      end
   end

   // Stage 1: capture operands and the conjugate flag of an accepted sample.
   // NOTE: datapath registers carry no reset; the valid bits alone decide
   // whether their contents mean anything, so reset only the control path.
   always_ff @(posedge clk) begin
      if (en && in_valid) begin
         a1    <= $signed(in_re);
         b1    <= $signed(in_im);
         c1    <= $signed(tw_re);
         d1    <= $signed(tw_im);
         conj1 <= in_conj;
      end
   end

   // Stage 2: the four full-precision partial products.
   always_ff @(posedge clk) begin
      if (en && v1) begin
         p_ac  <= PW'(a1) * PW'(c1);
         p_bd  <= PW'(b1) * PW'(d1);
         p_ad  <= PW'(a1) * PW'(d1);
         p_bc  <= PW'(b1) * PW'(c1);
         conj2 <= conj1;
      end
   end

   // Stage 3 combinational: add/sub per mode, then round and saturate each rail.
   // NOTE: every output of this block is assigned on every path, so no latch
   // can be inferred.
   always_comb begin
      re_sum = conj2 ? (SW'(p_ac) + SW'(p_bd)) : (SW'(p_ac) - SW'(p_bd));
      im_sum = conj2 ? (SW'(p_bc) - SW'(p_ad)) : (SW'(p_ad) + SW'(p_bc));
      rnd_sat(re_sum, re_q, re_ovf);
      rnd_sat(im_sum, im_q, im_ovf);
   end

   // Stage 3 register: outputs load only when a valid result advances, so
   // they hold through stalls and bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_re  <= '0;
         out_im  <= '0;
         out_ovf <= 1'b0;
      end else if (en && v2) begin
         out_re  <= re_q;
         out_im  <= im_q;
         out_ovf <= re_ovf || im_ovf;
      end
   end

   // Count handshaken results that saturated; clear wins, count sticks at max.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         ovf_count <= '0;
      end else if (v3 && out_ready && out_ovf && (ovf_count != '1)) begin
         ovf_count <= ovf_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_cmult_pipe.sv
// tb_cmult_pipe: self-checking bench for cmult_pipe. Directed table vectors
// with hand-computed results, a randomized backpressure stream checked against
// an arithmetic reference model, and reset / statistics corner sequences.
module tb_cmult_pipe;

   localparam int DW   = 16;
   localparam int TW   = 12;
   localparam int FRAC = 10;
   localparam int CNTW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic            in_conj;
   logic [DW-1:0]   in_re, in_im;
   logic [TW-1:0]   tw_re, tw_im;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_re, out_im;
   logic            out_ovf;
   logic            clr_stats;
   logic [CNTW-1:0] ovf_count;

   cmult_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC), .CNTW(CNTW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_conj   (in_conj),
      .in_re     (in_re),
      .in_im     (in_im),
      .tw_re     (tw_re),
      .tw_im     (tw_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_ovf   (out_ovf),
      .clr_stats (clr_stats),
      .ovf_count (ovf_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a, b, c, d;
      bit conj;
      int re, im;
      bit ovf;
   } vec_t;

   typedef struct {
      int re, im;
      bit ovf;
      bit lat;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[11];

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   exp_cnt  = 0;
   bit   started  = 1'b0;
   bit   bp_mode  = 1'b0;
   bit   prev_stall = 1'b0;
   logic [DW-1:0] held_re, held_im;
   logic          held_ovf;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input longint act, input longint req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: exact integer arithmetic, floor(x/2^FRAC + 1/2), then clamp.
   function automatic int round_sat(input longint x, output bit o);
      longint y, hi, lo;
      y  = (x + (longint'(1) << (FRAC - 1))) >>> FRAC;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -(longint'(1) << (DW - 1));
      o  = 1'b0;
      if (y > hi) begin y = hi; o = 1'b1; end
      if (y < lo) begin y = lo; o = 1'b1; end
      return int'(y);
   endfunction

   function automatic void model(input int a, b, c, d, input bit conj,
                                 output int re, im, output bit ovf);
      longint xr, xi;
      bit o1, o2;
      if (!conj) begin
         xr = longint'(a) * c - longint'(b) * d;
         xi = longint'(a) * d + longint'(b) * c;
      end else begin
         xr = longint'(a) * c + longint'(b) * d;
         xi = longint'(b) * c - longint'(a) * d;
      end
      re  = round_sat(xr, o1);
      im  = round_sat(xi, o2);
      ovf = o1 | o2;
   endfunction

   // Advance one cycle; drive point is 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = ($urandom_range(0, 1) != 0);
   endtask

   // Present one sample until accepted; record the expected result on acceptance.
   task automatic send(input int a, b, c, d, input bit conj,
                       input int er, ei, input bit eo, input bit lat);
      int waited;
      bit done;
      waited   = 0;
      done     = 1'b0;
      in_valid = 1'b1;
      in_re    = a[DW-1:0];
      in_im    = b[DW-1:0];
      tw_re    = c[TW-1:0];
      tw_im    = d[TW-1:0];
      in_conj  = conj;
      while (!done) begin
         #1;
         if (in_ready && !rst) begin
            sb.push_back(exp_t'{er, ei, eo, lat, cyc});
            done = 1'b1;
         end
         tick();
         waited++;
         if (!done && waited > 200) begin
            check(1'b0, "in_ready_timeout", 0, 1);
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      check(sb.size() == 0, "drain", sb.size(), 0);
   endtask

   // Output monitor: scoreboard order, stall stability, ready rule, counter.
   always @(negedge clk) begin
      if (started) begin
         check(int'(ovf_count) == exp_cnt, "ovf_count", ovf_count, exp_cnt);
         if (rst) begin
            sb.delete();
            exp_cnt    = 0;
            prev_stall = 1'b0;
         end else begin
            check(in_ready == (!out_valid || out_ready), "in_ready_rule",
                  in_ready, !out_valid || out_ready);
            if (prev_stall)
               check(out_valid && out_re == held_re && out_im == held_im && out_ovf == held_ovf,
                     "stall_hold", {out_valid, out_re, out_im}, {1'b1, held_re, held_im});
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check(1'b0, "spurious_output", $signed(out_re), 0);
               end else begin
                  mon_e = sb.pop_front();
                  check($signed(out_re) == mon_e.re, "out_re", $signed(out_re), mon_e.re);
                  check($signed(out_im) == mon_e.im, "out_im", $signed(out_im), mon_e.im);
                  check(out_ovf == mon_e.ovf, "out_ovf", out_ovf, mon_e.ovf);
                  if (mon_e.lat) check(cyc - mon_e.cyc == 3, "latency", cyc - mon_e.cyc, 3);
                  if (mon_e.ovf && exp_cnt < (1 << CNTW) - 1) exp_cnt++;
               end
            end
            if (clr_stats) exp_cnt = 0;
            prev_stall = out_valid && !out_ready;
            held_re    = out_re;
            held_im    = out_im;
            held_ovf   = out_ovf;
         end
      end
   end

   initial begin
      int ra, rb, rc, rd, er, ei, n_ovf;
      bit rconj, eo;

      //          a       b       c      d    conj   re      im     ovf
      vecs[0]  = '{1000,  0,      1024,  0,    0,  1000,   0,      0};
      vecs[1]  = '{0,     1000,   0,     1024, 0,  -1000,  0,      0};
      vecs[2]  = '{0,     1000,   0,     1024, 1,  1000,   0,      0};
      vecs[3]  = '{1,     0,      512,   0,    0,  1,      0,      0};
      vecs[4]  = '{-1,    0,      512,   0,    0,  0,      0,      0};
      vecs[5]  = '{-3,    0,      512,   0,    0,  -1,     0,      0};
      vecs[6]  = '{32767, -32768, 2047,  2047, 0,  32767,  -2,     1};
      vecs[7]  = '{-32768, 0,     2047,  0,    0,  -32768, 0,      1};
      vecs[8]  = '{-32768, -32768, 2047, -2048, 1, 32,     -32768, 1};
      vecs[9]  = '{32767, 0,      1024,  0,    0,  32767,  0,      0};
      vecs[10] = '{32767, 0,      1025,  0,    0,  32767,  0,      1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_conj   = 1'b0;
      in_re     = '0;
      in_im     = '0;
      tw_re     = '0;
      tw_im     = '0;
      out_ready = 1'b1;
      clr_stats = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
      check(out_re == '0, "reset_out_re", out_re, 0);
      check(out_im == '0, "reset_out_im", out_im, 0);
      check(out_ovf == 1'b0, "reset_out_ovf", out_ovf, 0);
      check(ovf_count == '0, "reset_ovf_count", ovf_count, 0);
      check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
      started = 1'b1;

      // Directed table, streamed back-to-back with no backpressure.
      n_ovf = 0;
      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].conj,
              vecs[i].re, vecs[i].im, vecs[i].ovf, 1'b1);
         if (vecs[i].ovf) n_ovf++;
      end
      wait_drain();
      tick();
      check(int'(ovf_count) == n_ovf, "ovf_count_table", ovf_count, n_ovf);

      // Single clear pulse.
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check(ovf_count == '0, "clr_stats", ovf_count, 0);

      // Clear held across a saturating handshake: clear must win.
      clr_stats = 1'b1;
      send(32767, -32768, 2047, 2047, 1'b0, 32767, -2, 1'b1, 1'b1);
      repeat (4) tick();
      clr_stats = 1'b0;
      wait_drain();
      check(ovf_count == '0, "clr_priority", ovf_count, 0);

      // Randomized stream under pseudo-random backpressure.
      bp_mode = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if ($urandom_range(0, 3) == 0) tick();
         ra    = int'($urandom_range(0, 65535)) - 32768;
         rb    = int'($urandom_range(0, 65535)) - 32768;
         rc    = int'($urandom_range(0, 4095)) - 2048;
         rd    = int'($urandom_range(0, 4095)) - 2048;
         rconj = ($urandom_range(0, 1) != 0);
         model(ra, rb, rc, rd, rconj, er, ei, eo);
         send(ra, rb, rc, rd, rconj, er, ei, eo, 1'b0);
      end
      bp_mode   = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // Reset with three samples in flight: all must be discarded.
      for (int k = 0; k < 3; k++) begin
         model(100 * (k + 1), -50, 700, 300, 1'b0, er, ei, eo);
         send(100 * (k + 1), -50, 700, 300, 1'b0, er, ei, eo, 1'b0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check(out_valid == 1'b0, "post_reset_out_valid", out_valid, 0);
      repeat (4) tick();
      model(-1234, 4321, -1000, 1500, 1'b1, er, ei, eo);
      send(-1234, 4321, -1000, 1500, 1'b1, er, ei, eo, 1'b1);
      wait_drain();

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
